// File: rtl/slow_clock_meter.sv
// Measures period and high time of an asynchronous slow clock in clk cycles,
// tracking lock and loss of the signal.
module slow_clock_meter #(
  parameter int F_CLK       = 50000000,
  parameter int MAX_PERIOD  = F_CLK,
  parameter int SYNC_STAGES = 2,
  localparam int W          = $clog2(MAX_PERIOD + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         slow_in_i,
  output logic [W-1:0] period_o,
  output logic [W-1:0] high_time_o,
  output logic         period_valid_o,
  output logic         locked_o,
  output logic         lost_o
);

  localparam logic [W-1:0] MAXV = W'(MAX_PERIOD);
  localparam logic [W-1:0] ONE  = W'(1);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, LOST} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [W-1:0]           cnt_q, hcnt_q, hi_shadow_q;
  logic [W-1:0]           period_q, high_q;
  logic                   valid_q;
  logic                   s, rise, fall, upd, timeout;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~prev_q;
  assign fall    = ~s & prev_q;
  assign timeout = (cnt_q == MAXV);
  // A rise only yields a measurement when the previous edge is known and recent.
  assign upd     = rise && (state_q == ARMED || state_q == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in_i};
      prev_q <= s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      hcnt_q      <= '0;
      hi_shadow_q <= '0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      if (rise)              cnt_q <= ONE;
      else if (cnt_q < MAXV) cnt_q <= cnt_q + ONE;

      if (rise)                    hcnt_q <= ONE;
      else if (s && hcnt_q < MAXV) hcnt_q <= hcnt_q + ONE;

      if (fall) hi_shadow_q <= hcnt_q;

      valid_q <= upd;
      if (upd) begin
        period_q <= cnt_q;
        high_q   <= hi_shadow_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Rise takes priority over timeout so a period of exactly MAX_PERIOD is measured.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (rise) state_d = ARMED;
      ARMED:  if (rise) state_d = LOCKED;
              else if (timeout) state_d = LOST;
      LOCKED: if (rise) state_d = LOCKED;
              else if (timeout) state_d = LOST;
      LOST:   if (rise) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    locked_o       = (state_q == LOCKED);
    lost_o         = (state_q == LOST);
    period_valid_o = valid_q;
    period_o       = period_q;
    high_time_o    = high_q;
  end

endmodule
